register_file_wb: RTL and testbench

REGISTER_FILE_WB -- requirements
Module: register_file_wb

---
 rtl/register_file_wb.sv | 87 ++++++++
 tb/tb_register_file_wb.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_wb.sv
// Register file with write-back bypass and per-register pending (scoreboard) bits.
// Reads are combinational; writes, reservations and the pending count update on Clk.
module register_file_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic              Reserve,
  input  logic [ADDR_W-1:0] ReserveRegister,
  output logic              Hazard1,
  output logic              Hazard2,
  output logic [ADDR_W:0]   PendingCount
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   pending;
  logic [NREG-1:0]   pending_nxt;
  logic [ADDR_W:0]   count_nxt;
  logic              wr_en;
  logic              rsv_en;

  assign wr_en  = RegWrite && (WriteRegister != '0);
  assign rsv_en = Reserve && (ReserveRegister != '0);

  // Clear for the write-back first, then set for the reservation, so a
  // same-index reserve wins over the write-back.
  always_comb begin
    pending_nxt = pending;
    if (wr_en)  pending_nxt[WriteRegister]   = 1'b0;
    if (rsv_en) pending_nxt[ReserveRegister] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_comb begin
    count_nxt = '0;
    for (int i = 0; i < NREG; i++) begin
      count_nxt = count_nxt + {{ADDR_W{1'b0}}, pending_nxt[i]};
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      // NOTE: the register array is reset explicitly because reads after reset
      // must return 0; this forces flops rather than a RAM macro.
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      pending      <= '0;
      PendingCount <= '0;
    end else begin
      if (wr_en) begin
        regs[WriteRegister] <= WriteData;
      end
      pending      <= pending_nxt;
      PendingCount <= count_nxt;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] idx);
    if (idx == '0)
      return '0;
    else if (RegWrite && (WriteRegister == idx))
      return WriteData;
    else
      return regs[idx];
  endfunction

  function automatic logic hazard_port(input logic [ADDR_W-1:0] idx);
    return (idx != '0) && pending[idx] && !(RegWrite && (WriteRegister == idx));
  endfunction

  assign ReadData1 = read_port(ReadRegister1);
  assign ReadData2 = read_port(ReadRegister2);
  assign Hazard1   = hazard_port(ReadRegister1);
  assign Hazard2   = hazard_port(ReadRegister2);

endmodule

// File: tb/tb_register_file_wb.sv
// Scoreboard bench for register_file_wb: expectations are queued as stimulus is
// driven and compared against the outputs sampled on the following falling edge.
module tb_register_file_wb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              Clk = 1'b0;
  logic              Rst_n;
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] ReadRegister1;
  logic [ADDR_W-1:0] ReadRegister2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic              Reserve;
  logic [ADDR_W-1:0] ReserveRegister;
  logic              Hazard1;
  logic              Hazard2;
  logic [ADDR_W:0]   PendingCount;

  typedef struct packed {
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              h1;
    logic              h2;
    logic [ADDR_W:0]   cnt;
  } obs_t;

  typedef struct {
    string nm;
    obs_t  v;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  obs_t o;
  int   total = 0;
  int   bad   = 0;

  register_file_wb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .Reserve(Reserve), .ReserveRegister(ReserveRegister),
    .Hazard1(Hazard1), .Hazard2(Hazard2), .PendingCount(PendingCount)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic obs_t get_obs();
    return '{rd1: ReadData1, rd2: ReadData2, h1: Hazard1, h2: Hazard2, cnt: PendingCount};
  endfunction

  // Drive one cycle's inputs and queue the outputs expected before the next edge.
  task automatic drive_exp(input string nm, input logic rst, input logic rw,
                           input logic [ADDR_W-1:0] wr, input logic [DATA_W-1:0] wd,
                           input logic rsv, input logic [ADDR_W-1:0] rsvr,
                           input logic [ADDR_W-1:0] rr1, input logic [ADDR_W-1:0] rr2,
                           input logic [DATA_W-1:0] x1, input logic [DATA_W-1:0] x2,
                           input logic xh1, input logic xh2, input logic [ADDR_W:0] xc);
    exp_t t;
    Rst_n = rst; RegWrite = rw; WriteRegister = wr; WriteData = wd;
    Reserve = rsv; ReserveRegister = rsvr;
    ReadRegister1 = rr1; ReadRegister2 = rr2;
    t.nm = nm;
    t.v  = '{rd1: x1, rd2: x2, h1: xh1, h2: xh2, cnt: xc};
    exp_q.push_back(t);
  endtask

  task automatic test_reset();
    // Reset edge with a write and reservation present; both must be ignored.
    Rst_n = 1'b0; RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 32'hAAAA_5555;
    Reserve = 1'b1; ReserveRegister = 5'd7; ReadRegister1 = '0; ReadRegister2 = '0;
    @(posedge Clk); #1;
    for (int s = 0; s < 3; s++) begin
      case (s)
        0: drive_exp("reset_r7", 1, 0, 0, 0, 0, 0, 7, 7, 0, 0, 0, 0, 0);
        1: drive_exp("reset_r1_r31", 1, 0, 0, 0, 0, 0, 1, 31, 0, 0, 0, 0, 0);
        default: drive_exp("reset_r16_r0", 1, 0, 0, 0, 0, 0, 16, 0, 0, 0, 0, 0, 0);
      endcase
      @(negedge Clk);
      e = exp_q.pop_front(); o = get_obs(); total++;
      if (o !== e.v) begin
        bad++;
        $display("FAIL %s: got rd1=%h rd2=%h h=%b%b cnt=%0d want rd1=%h rd2=%h h=%b%b cnt=%0d",
                 e.nm, o.rd1, o.rd2, o.h1, o.h2, o.cnt, e.v.rd1, e.v.rd2, e.v.h1, e.v.h2, e.v.cnt);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_write_read();
    for (int s = 0; s < 6; s++) begin
      case (s)
        0: drive_exp("wr_r8_bypass", 1, 1, 8, 32'hDEAD_BEEF, 0, 0, 8, 8, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 0);
        1: drive_exp("rd_r8", 1, 0, 0, 0, 0, 0, 8, 8, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 0);
        2: drive_exp("wr_r31", 1, 1, 31, 32'h0BAD_F00D, 0, 0, 31, 8, 32'h0BAD_F00D, 32'hDEAD_BEEF, 0, 0, 0);
        3: drive_exp("rd_r8_r31", 1, 0, 0, 0, 0, 0, 8, 31, 32'hDEAD_BEEF, 32'h0BAD_F00D, 0, 0, 0);
        4: drive_exp("wr_r0", 1, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        default: drive_exp("rd_r0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      @(negedge Clk);
      e = exp_q.pop_front(); o = get_obs(); total++;
      if (o !== e.v) begin
        bad++;
        $display("FAIL %s: got rd1=%h rd2=%h h=%b%b cnt=%0d want rd1=%h rd2=%h h=%b%b cnt=%0d",
                 e.nm, o.rd1, o.rd2, o.h1, o.h2, o.cnt, e.v.rd1, e.v.rd2, e.v.h1, e.v.h2, e.v.cnt);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_bypass();
    for (int s = 0; s < 3; s++) begin
      case (s)
        0: drive_exp("bypass_r5", 1, 1, 5, 32'h1234, 0, 0, 5, 6, 32'h1234, 0, 0, 0, 0);
        1: drive_exp("bypass_over", 1, 1, 5, 32'h5678, 0, 0, 5, 5, 32'h5678, 32'h5678, 0, 0, 0);
        default: drive_exp("rd_r5", 1, 0, 0, 0, 0, 0, 5, 8, 32'h5678, 32'hDEAD_BEEF, 0, 0, 0);
      endcase
      @(negedge Clk);
      e = exp_q.pop_front(); o = get_obs(); total++;
      if (o !== e.v) begin
        bad++;
        $display("FAIL %s: got rd1=%h rd2=%h h=%b%b cnt=%0d want rd1=%h rd2=%h h=%b%b cnt=%0d",
                 e.nm, o.rd1, o.rd2, o.h1, o.h2, o.cnt, e.v.rd1, e.v.rd2, e.v.h1, e.v.h2, e.v.cnt);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_reserve();
    for (int s = 0; s < 12; s++) begin
      case (s)
        0:  drive_exp("rsv_r9", 1, 0, 0, 0, 1, 9, 9, 0, 0, 0, 0, 0, 0);
        1:  drive_exp("rsv_r9_haz", 1, 0, 0, 0, 0, 0, 9, 9, 0, 0, 1, 1, 1);
        2:  drive_exp("wb_r9", 1, 1, 9, 32'h55, 0, 0, 9, 9, 32'h55, 32'h55, 0, 0, 1);
        3:  drive_exp("wb_r9_done", 1, 0, 0, 0, 0, 0, 9, 0, 32'h55, 0, 0, 0, 0);
        4:  drive_exp("rsv_wr_r3", 1, 1, 3, 32'h77, 1, 3, 3, 3, 32'h77, 32'h77, 0, 0, 0);
        5:  drive_exp("rsv_wins_r3", 1, 0, 0, 0, 0, 0, 3, 3, 32'h77, 32'h77, 1, 1, 1);
        6:  drive_exp("rsv_again_r3", 1, 0, 0, 0, 1, 3, 3, 0, 32'h77, 0, 1, 0, 1);
        7:  drive_exp("rsv_again_cnt", 1, 0, 0, 0, 0, 0, 3, 3, 32'h77, 32'h77, 1, 1, 1);
        8:  drive_exp("rsv10_wr3", 1, 1, 3, 32'h99, 1, 10, 3, 10, 32'h99, 0, 0, 0, 1);
        9:  drive_exp("rsv10_wr3_after", 1, 0, 0, 0, 0, 0, 3, 10, 32'h99, 0, 0, 1, 1);
        10: drive_exp("rsv_r0", 1, 1, 0, 32'hFFFF_FFFF, 1, 0, 0, 10, 0, 0, 0, 1, 1);
        default: drive_exp("rsv_r0_after", 1, 0, 0, 0, 0, 0, 0, 10, 0, 0, 0, 1, 1);
      endcase
      @(negedge Clk);
      e = exp_q.pop_front(); o = get_obs(); total++;
      if (o !== e.v) begin
        bad++;
        $display("FAIL %s: got rd1=%h rd2=%h h=%b%b cnt=%0d want rd1=%h rd2=%h h=%b%b cnt=%0d",
                 e.nm, o.rd1, o.rd2, o.h1, o.h2, o.cnt, e.v.rd1, e.v.rd2, e.v.h1, e.v.h2, e.v.cnt);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    // r10 is still pending from the previous task.
    for (int s = 0; s < 8; s++) begin
      case (s)
        0: drive_exp("mid_rsv_r1", 1, 0, 0, 0, 1, 1, 1, 10, 0, 0, 0, 1, 1);
        1: drive_exp("mid_rsv_r2", 1, 0, 0, 0, 1, 2, 1, 2, 0, 0, 1, 0, 2);
        2: drive_exp("mid_rsv_r4", 1, 0, 0, 0, 1, 4, 2, 4, 0, 0, 1, 0, 3);
        3: drive_exp("mid_pending", 1, 0, 0, 0, 0, 0, 4, 1, 0, 0, 1, 1, 4);
        4: drive_exp("mid_rst_edge", 0, 0, 0, 0, 0, 0, 4, 8, 0, 32'hDEAD_BEEF, 1, 0, 4);
        5: drive_exp("mid_after_r4_r8", 1, 0, 0, 0, 0, 0, 4, 8, 0, 0, 0, 0, 0);
        6: drive_exp("mid_after_r1_r2", 1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0);
        default: drive_exp("mid_after_r9_r10", 1, 0, 0, 0, 0, 0, 9, 10, 0, 0, 0, 0, 0);
      endcase
      @(negedge Clk);
      e = exp_q.pop_front(); o = get_obs(); total++;
      if (o !== e.v) begin
        bad++;
        $display("FAIL %s: got rd1=%h rd2=%h h=%b%b cnt=%0d want rd1=%h rd2=%h h=%b%b cnt=%0d",
                 e.nm, o.rd1, o.rd2, o.h1, o.h2, o.cnt, e.v.rd1, e.v.rd2, e.v.h1, e.v.h2, e.v.cnt);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    // Reserve every register on consecutive cycles, then write them all back.
    logic [ADDR_W-1:0] j;
    logic [DATA_W-1:0] d;
    for (int s = 0; s < 64; s++) begin
      if (s < 31) begin
        j = ADDR_W'(s + 1);
        drive_exp("b2b_reserve", 1, 0, 0, 0, 1, j, j, ADDR_W'(s), 0, 0, 0, (s > 0), (ADDR_W+1)'(s));
      end else if (s == 31) begin
        drive_exp("b2b_full", 1, 0, 0, 0, 0, 0, 31, 1, 0, 0, 1, 1, 6'd31);
      end else if (s < 63) begin
        j = ADDR_W'(s - 31);
        d = DATA_W'(s - 31) * 32'h0101_0101;
        drive_exp("b2b_writeback", 1, 1, j, d, 0, 0, j, 31, d, (j == 31) ? d : 32'h0, 0,
                  (j != 31), (ADDR_W+1)'(63 - s));
      end else begin
        drive_exp("b2b_drained", 1, 0, 0, 0, 0, 0, 31, 1, 32'h1F1F_1F1F, 32'h0101_0101, 0, 0, 0);
      end
      @(negedge Clk);
      e = exp_q.pop_front(); o = get_obs(); total++;
      if (o !== e.v) begin
        bad++;
        $display("FAIL %s[%0d]: got rd1=%h rd2=%h h=%b%b cnt=%0d want rd1=%h rd2=%h h=%b%b cnt=%0d",
                 e.nm, s, o.rd1, o.rd2, o.h1, o.h2, o.cnt, e.v.rd1, e.v.rd2, e.v.h1, e.v.h2, e.v.cnt);
      end
      @(posedge Clk); #1;
    end
  endtask

  initial begin
    Rst_n = 1'b0; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
    Reserve = 1'b0; ReserveRegister = '0; ReadRegister1 = '0; ReadRegister2 = '0;
    @(posedge Clk); #1;
    test_reset();
    test_write_read();
    test_bypass();
    test_reserve();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
